// File: rtl/riscv_pkg.sv
// Shared control-flow definitions for the fetch-side sequencer.
package riscv_pkg;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_JALR   = 2'b01;
    localparam logic [1:0] PC_SEL_TARGET = 2'b11;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_FLUSH = 2'b01,
        ST_HALT  = 2'b10
    } seq_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Control-flow target computation for the instruction currently in EX.
module pc_target_calc
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      pc_sel,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    // JALR takes the ALU sum with bit0 forced low; everything else uses the PC-relative sum.
    always_comb begin
        if (pc_sel == PC_SEL_JALR) begin
            target = alu_result & ~XLEN'(1);
        end else begin
            target = ex_pc + ex_imm;
        end
        misaligned = target[1];
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: fetch requests, redirects, flushes and misaligned-target halt.
module pc_sequencer
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          XLEN       = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic [1:0]      i_pc_sel,
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic [XLEN-1:0] i_ex_imm,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic            i_imem_ready,
    output logic [XLEN-1:0] o_pc,
    output logic            o_imem_req,
    output logic            o_if_valid,
    output logic            o_flush_ifid,
    output logic            o_flush_idex,
    output logic            o_halt,
    output logic [XLEN-1:0] o_trap_pc
);

    seq_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            if_valid_q, if_valid_d;
    logic            halt_q, halt_d;
    logic [XLEN-1:0] trap_pc_q, trap_pc_d;

    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            redirect;
    logic            imem_req;
    logic            flush;

    pc_target_calc #(
        .XLEN(XLEN)
    ) u_target (
        .pc_sel     (i_pc_sel),
        .ex_pc      (i_ex_pc),
        .ex_imm     (i_ex_imm),
        .alu_result (i_alu_result),
        .target     (target),
        .misaligned (misaligned)
    );

    assign redirect = ((i_pc_sel == PC_SEL_JALR) || (i_pc_sel == PC_SEL_TARGET))
                      && (state_q != ST_HALT);

    // Next-state and outputs: halt > redirect > stall > advance; reset masks the strobes.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = 1'b0;
        halt_d     = halt_q;
        trap_pc_d  = trap_pc_q;
        imem_req   = 1'b0;
        flush      = 1'b0;

        if (state_q == ST_HALT) begin
            state_d = ST_HALT;
        end else if (redirect) begin
            flush = 1'b1;
            if (misaligned) begin
                state_d   = ST_HALT;
                halt_d    = 1'b1;
                trap_pc_d = i_ex_pc;
            end else begin
                pc_d    = target;
                state_d = ST_FLUSH;
            end
        end else if (i_stall) begin
            state_d = ST_RUN;
        end else begin
            imem_req = 1'b1;
            state_d  = ST_RUN;
            if (i_imem_ready) begin
                pc_d       = pc_q + XLEN'(INSTR_BYTES);
                if_valid_d = 1'b1;
            end
        end

        if (i_rst) begin
            imem_req = 1'b0;
            flush    = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_RUN;
            pc_q       <= XLEN'(RESET_ADDR);
            if_valid_q <= 1'b0;
            halt_q     <= 1'b0;
            trap_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            halt_q     <= halt_d;
            trap_pc_q  <= trap_pc_d;
        end
    end

    assign o_pc         = pc_q;
    assign o_imem_req   = imem_req;
    assign o_if_valid   = if_valid_q;
    assign o_flush_ifid = flush;
    assign o_flush_idex = flush;
    assign o_halt       = halt_q;
    assign o_trap_pc    = trap_pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed table, hand sequences, randomized model run.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  pc_sel;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] alu_result;
    logic        imem_ready;
    logic [31:0] pc;
    logic        imem_req;
    logic        if_valid;
    logic        flush_ifid;
    logic        flush_idex;
    logic        halt;
    logic [31:0] trap_pc;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: architectural view only (PC, pending fetch response, halt status).
    logic [31:0] m_pc;
    logic        m_resp_pending;
    logic        m_halted;
    logic [31:0] m_trap;

    typedef struct {
        logic        rst;
        logic        stall;
        logic [1:0]  sel;
        logic [31:0] ex_pc;
        logic [31:0] imm;
        logic [31:0] alu;
        logic        ready;
        logic [31:0] e_pc;
        logic        e_req;
        logic        e_ifv;
        logic        e_flush;
        logic        e_halt;
        logic [31:0] e_trap;
    } vec_t;

    vec_t tbl[$];

    pc_sequencer #(
        .RESET_ADDR(32'h0000_0000),
        .XLEN      (32)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_stall      (stall),
        .i_pc_sel     (pc_sel),
        .i_ex_pc      (ex_pc),
        .i_ex_imm     (ex_imm),
        .i_alu_result (alu_result),
        .i_imem_ready (imem_ready),
        .o_pc         (pc),
        .o_imem_req   (imem_req),
        .o_if_valid   (if_valid),
        .o_flush_ifid (flush_ifid),
        .o_flush_idex (flush_idex),
        .o_halt       (halt),
        .o_trap_pc    (trap_pc)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic s, input logic [1:0] sl,
                                input logic [31:0] ep, input logic [31:0] im,
                                input logic [31:0] al, input logic rd,
                                input logic [31:0] xpc, input logic xreq, input logic xifv,
                                input logic xfl, input logic xhalt, input logic [31:0] xtrap);
        vec_t v;
        v.rst = r; v.stall = s; v.sel = sl; v.ex_pc = ep; v.imm = im; v.alu = al;
        v.ready = rd; v.e_pc = xpc; v.e_req = xreq; v.e_ifv = xifv; v.e_flush = xfl;
        v.e_halt = xhalt; v.e_trap = xtrap;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs mid-period, optionally compare against the model, then advance the model.
    task automatic applyStimulus(input logic r, input logic s, input logic [1:0] sl,
                                 input logic [31:0] ep, input logic [31:0] im,
                                 input logic [31:0] al, input logic rd, input bit model_check);
        logic        exp_req;
        logic        exp_flush;
        logic        is_redirect;
        logic [31:0] tgt;
        @(negedge clk);
        rst = r; stall = s; pc_sel = sl; ex_pc = ep; ex_imm = im; alu_result = al; imem_ready = rd;
        #1;
        is_redirect = (sl == 2'b01 || sl == 2'b11) && !m_halted;
        exp_req   = !r && !m_halted && !is_redirect && !s;
        exp_flush = !r && is_redirect;
        if (model_check) begin
            checkOutput("m_pc", pc, m_pc);
            checkOutput("m_req", 32'(imem_req), 32'(exp_req));
            checkOutput("m_ifv", 32'(if_valid), 32'(m_resp_pending));
            checkOutput("m_flush_ifid", 32'(flush_ifid), 32'(exp_flush));
            checkOutput("m_flush_idex", 32'(flush_idex), 32'(exp_flush));
            checkOutput("m_halt", 32'(halt), 32'(m_halted));
            checkOutput("m_trap", trap_pc, m_trap);
        end
        if (r) begin
            m_pc = 32'h0; m_resp_pending = 1'b0; m_halted = 1'b0; m_trap = 32'h0;
        end else if (m_halted) begin
            m_resp_pending = 1'b0;
        end else if (is_redirect) begin
            tgt = (sl == 2'b11) ? ep + im : (al / 2) * 2;
            m_resp_pending = 1'b0;
            if (((tgt / 2) % 2) != 0) begin
                m_halted = 1'b1;
                m_trap   = ep;
            end else begin
                m_pc = tgt;
            end
        end else if (s) begin
            m_resp_pending = 1'b0;
        end else begin
            m_resp_pending = rd;
            if (rd) m_pc = m_pc + 32'd4;
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; pc_sel = 2'b00; ex_pc = '0; ex_imm = '0;
        alu_result = '0; imem_ready = 1'b1;
        m_pc = '0; m_resp_pending = 1'b0; m_halted = 1'b0; m_trap = '0;

        // Power-up reset cycle: outputs undefined before the first edge.
        applyStimulus(1'b1, 1'b0, 2'b00, 0, 0, 0, 1'b1, 1'b0);

        //             rst  stl  sel    ex_pc         imm           alu          rdy   pc            req  ifv  fl   hlt  trap
        tbl.push_back(mk(1, 0, 2'b00, 32'h0,       32'h0,        32'h0,       1,   32'h00,      0,   0,   0,   0,   32'h0));
        tbl.push_back(mk(0, 0, 2'b00, 32'h0,       32'h0,        32'h0,       1,   32'h00,      1,   0,   0,   0,   32'h0));
        tbl.push_back(mk(0, 0, 2'b00, 32'h0,       32'h0,        32'h0,       1,   32'h04,      1,   1,   0,   0,   32'h0));
        tbl.push_back(mk(0, 0, 2'b00, 32'h0,       32'h0,        32'h0,       1,   32'h08,      1,   1,   0,   0,   32'h0));
        tbl.push_back(mk(0, 0, 2'b00, 32'h0,       32'h0,        32'h0,       1,   32'h0C,      1,   1,   0,   0,   32'h0));
        tbl.push_back(mk(0, 0, 2'b00, 32'h0,       32'h0,        32'h0,       1,   32'h10,      1,   1,   0,   0,   32'h0));
        tbl.push_back(mk(0, 0, 2'b00, 32'h0,       32'h0,        32'h0,       1,   32'h14,      1,   1,   0,   0,   32'h0));
        tbl.push_back(mk(0, 0, 2'b00, 32'h0,       32'h0,        32'h0,       1,   32'h18,      1,   1,   0,   0,   32'h0));
        tbl.push_back(mk(0, 0, 2'b00, 32'h0,       32'h0,        32'h0,       1,   32'h1C,      1,   1,   0,   0,   32'h0));
        tbl.push_back(mk(0, 0, 2'b00, 32'h0,       32'h0,        32'h0,       0,   32'h20,      1,   1,   0,   0,   32'h0));
        tbl.push_back(mk(0, 0, 2'b00, 32'h0,       32'h0,        32'h0,       0,   32'h20,      1,   0,   0,   0,   32'h0));
        tbl.push_back(mk(0, 0, 2'b00, 32'h0,       32'h0,        32'h0,       1,   32'h20,      1,   0,   0,   0,   32'h0));
        tbl.push_back(mk(0, 0, 2'b00, 32'h0,       32'h0,        32'h0,       1,   32'h24,      1,   1,   0,   0,   32'h0));
        tbl.push_back(mk(0, 1, 2'b11, 32'h100,     32'hFFFF_FFF0, 32'h0,      1,   32'h28,      0,   1,   1,   0,   32'h0));
        tbl.push_back(mk(0, 0, 2'b00, 32'h0,       32'h0,        32'h0,       1,   32'hF0,      1,   0,   0,   0,   32'h0));
        tbl.push_back(mk(0, 0, 2'b00, 32'h0,       32'h0,        32'h0,       1,   32'hF4,      1,   1,   0,   0,   32'h0));
        tbl.push_back(mk(0, 0, 2'b11, 32'h30,      32'h10,       32'h0,       1,   32'hF8,      0,   1,   1,   0,   32'h0));
        tbl.push_back(mk(0, 0, 2'b11, 32'h10,      32'h30,       32'h0,       1,   32'h40,      0,   0,   1,   0,   32'h0));
        tbl.push_back(mk(0, 0, 2'b00, 32'h0,       32'h0,        32'h0,       1,   32'h40,      1,   0,   0,   0,   32'h0));
        tbl.push_back(mk(0, 0, 2'b00, 32'h0,       32'h0,        32'h0,       1,   32'h44,      1,   1,   0,   0,   32'h0));
        tbl.push_back(mk(0, 0, 2'b11, 32'h0,       32'h80,       32'h0,       1,   32'h48,      0,   1,   1,   0,   32'h0));
        tbl.push_back(mk(1, 0, 2'b00, 32'h0,       32'h0,        32'h0,       1,   32'h80,      0,   0,   0,   0,   32'h0));
        tbl.push_back(mk(0, 0, 2'b00, 32'h0,       32'h0,        32'h0,       1,   32'h00,      1,   0,   0,   0,   32'h0));
        tbl.push_back(mk(0, 0, 2'b00, 32'h0,       32'h0,        32'h0,       1,   32'h04,      1,   1,   0,   0,   32'h0));
        tbl.push_back(mk(0, 0, 2'b01, 32'h55C,     32'h0,        32'h203,     1,   32'h08,      0,   1,   1,   0,   32'h0));
        tbl.push_back(mk(0, 1, 2'b11, 32'h0,       32'h40,       32'h0,       1,   32'h08,      0,   0,   0,   1,   32'h55C));
        tbl.push_back(mk(0, 0, 2'b01, 32'h0,       32'h0,        32'h0,       1,   32'h08,      0,   0,   0,   1,   32'h55C));
        tbl.push_back(mk(0, 0, 2'b00, 32'h0,       32'h0,        32'h0,       1,   32'h08,      0,   0,   0,   1,   32'h55C));
        tbl.push_back(mk(1, 0, 2'b00, 32'h0,       32'h0,        32'h0,       1,   32'h08,      0,   0,   0,   1,   32'h55C));
        tbl.push_back(mk(0, 0, 2'b00, 32'h0,       32'h0,        32'h0,       1,   32'h00,      1,   0,   0,   0,   32'h0));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].rst, tbl[i].stall, tbl[i].sel, tbl[i].ex_pc, tbl[i].imm,
                          tbl[i].alu, tbl[i].ready, 1'b0);
            checkOutput($sformatf("v%0d_pc", i), pc, tbl[i].e_pc);
            checkOutput($sformatf("v%0d_req", i), 32'(imem_req), 32'(tbl[i].e_req));
            checkOutput($sformatf("v%0d_ifv", i), 32'(if_valid), 32'(tbl[i].e_ifv));
            checkOutput($sformatf("v%0d_flush_ifid", i), 32'(flush_ifid), 32'(tbl[i].e_flush));
            checkOutput($sformatf("v%0d_flush_idex", i), 32'(flush_idex), 32'(tbl[i].e_flush));
            checkOutput($sformatf("v%0d_halt", i), 32'(halt), 32'(tbl[i].e_halt));
            checkOutput($sformatf("v%0d_trap", i), trap_pc, tbl[i].e_trap);
        end

        // PC wrap: jump to the last word, fetch it, expect address 0 next.
        applyStimulus(0, 0, 2'b11, 32'h0, 32'hFFFF_FFFC, 32'h0, 1, 1'b1);
        applyStimulus(0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 1, 1'b1);
        checkOutput("wrap_top", pc, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 1, 1'b1);
        checkOutput("wrap_zero", pc, 32'h0);
        // Illegal select behaves as sequential.
        applyStimulus(0, 0, 2'b10, 32'h1234, 32'h8, 32'h9, 1, 1'b1);
        checkOutput("illegal_no_flush", 32'(flush_ifid), 32'h0);
        // JALR with odd sum lands aligned after bit0 is cleared.
        applyStimulus(0, 0, 2'b01, 32'h0, 32'h0, 32'h301, 1, 1'b1);
        applyStimulus(0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 0, 1'b1);
        checkOutput("jalr_bit0", pc, 32'h300);
        // Misaligned PC-relative target traps with EX pc.
        applyStimulus(0, 0, 2'b11, 32'h100, 32'h2, 32'h0, 1, 1'b1);
        applyStimulus(0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 1, 1'b1);
        checkOutput("jal_trap_pc", trap_pc, 32'h100);
        applyStimulus(1, 0, 2'b00, 32'h0, 32'h0, 32'h0, 1, 1'b1);

        // Randomized run against the model; mostly aligned targets so halts stay occasional.
        for (int n = 0; n < 400; n++) begin
            logic        r_rst;
            logic        r_stall;
            logic [1:0]  r_sel;
            logic [31:0] r_ep;
            logic [31:0] r_imm;
            logic [31:0] r_alu;
            logic        r_rdy;
            r_rst   = ($urandom_range(0, 29) == 0);
            r_stall = ($urandom_range(0, 3) == 0);
            r_sel   = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            r_ep    = $urandom & 32'hFFFF_FFFC;
            r_imm   = ($urandom_range(0, 11) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            r_alu   = ($urandom_range(0, 11) == 0) ? $urandom
                                                   : (($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1)));
            r_rdy   = ($urandom_range(0, 3) != 0);
            applyStimulus(r_rst, r_stall, r_sel, r_ep, r_imm, r_alu, r_rdy, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
